// File: rtl/div_cmd_arb_pkg.sv
// Shared types and widths for the divider command arbiter.
// ADDR_WIDTH/DATA_WIDTH normally come from param_def.v; the defaults below apply when it is not included.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

package div_arb_pkg;
  localparam int CNT_W  = 3;
  localparam int ADDR_W = `ADDR_WIDTH;
  localparam int DATA_W = `DATA_WIDTH;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } arb_state_e;

  // 2'b11 and IDLE are granted but never reach the register file
  function automatic logic cmd_legal(input logic [1:0] c);
    return (c == READ) || (c == WRITE);
  endfunction
endpackage

// File: rtl/div_cmd_arb_if.sv
// Requester-side and register-file-side buses of the divider command arbiter.
interface div_cmd_arb_if #(
  parameter int N_REQ = 3
);
  logic [N_REQ-1:0]                            req_vld_i;
  logic [N_REQ-1:0][1:0]                       req_cmd_i;
  logic [N_REQ-1:0][div_arb_pkg::ADDR_W-1:0]   req_addr_i;
  logic [N_REQ-1:0][div_arb_pkg::DATA_W-1:0]   req_wdata_i;
  logic [N_REQ-1:0]                            req_gnt_o;
  logic [N_REQ-1:0]                            req_rvld_o;
  logic [div_arb_pkg::DATA_W-1:0]              req_rdata_o;
  logic [1:0]                                  cmd_opt_o;
  logic [div_arb_pkg::ADDR_W-1:0]              cmd_addr_o;
  logic [div_arb_pkg::DATA_W-1:0]              cmd_data_o;
  logic [div_arb_pkg::DATA_W-1:0]              cmd_rdata_i;
  logic                                        busy_o;

  modport master (
    output req_vld_i, req_cmd_i, req_addr_i, req_wdata_i, cmd_rdata_i,
    input  req_gnt_o, req_rvld_o, req_rdata_o, cmd_opt_o, cmd_addr_o, cmd_data_o, busy_o
  );

  modport slave (
    input  req_vld_i, req_cmd_i, req_addr_i, req_wdata_i, cmd_rdata_i,
    output req_gnt_o, req_rvld_o, req_rdata_o, cmd_opt_o, cmd_addr_o, cmd_data_o, busy_o
  );
endinterface

// File: rtl/div_cmd_arb_rr_pick.sv
// Combinational winner picker: round-robin from last_gnt+1, or fixed priority
// (lowest index wins) when DIV_CMD_ARB_FIXPRIO_EN is defined.
module div_rr_pick #(
  parameter  int N_REQ = 3,
  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last_gnt,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

`ifdef DIV_CMD_ARB_FIXPRIO_EN
  logic unused_last;
  assign unused_last = ^last_gnt;

  // Descending scan: the lowest requesting index is written last and wins
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt    = '0;
        gnt[i] = 1'b1;
        idx    = IDX_W'(i);
      end
    end
  end
`else
  // Scan offsets N_REQ..1 so the requester closest after last_gnt is written last
  always_comb begin
    gnt = '0;
    idx = '0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req[(int'(last_gnt) + i) % N_REQ]) begin
        gnt = '0;
        gnt[(int'(last_gnt) + i) % N_REQ] = 1'b1;
        idx = IDX_W'((int'(last_gnt) + i) % N_REQ);
      end
    end
  end
`endif

endmodule

// File: rtl/div_cmd_arb.sv
// Shares the divider register command port among N_REQ requesters, one command in flight.
// Build option: DIV_CMD_ARB_FIXPRIO_EN selects fixed priority instead of round-robin.
module div_cmd_arb
  import div_arb_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int RD_LAT = 1
) (
  input logic          clk_i,
  input logic          rst_i,
  div_cmd_arb_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state;
  logic [IDX_W-1:0]  last_gnt;
  logic [IDX_W-1:0]  owner;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        opt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] rdata_q;
  logic [N_REQ-1:0]  rvld_q;

  logic [N_REQ-1:0]  win_gnt;
  logic [IDX_W-1:0]  win_idx;
  logic [1:0]        win_cmd;

  div_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req      (bus.req_vld_i),
    .last_gnt (last_gnt),
    .gnt      (win_gnt),
    .idx      (win_idx)
  );

  assign win_cmd = bus.req_cmd_i[win_idx];

  // Grant only while idle and out of reset, so a single command is ever in flight
  assign bus.req_gnt_o   = (state == S_IDLE && !rst_i) ? win_gnt : '0;
  assign bus.req_rvld_o  = rvld_q;
  assign bus.req_rdata_o = rdata_q;
  assign bus.cmd_opt_o   = opt_q;
  assign bus.cmd_addr_o  = addr_q;
  assign bus.cmd_data_o  = data_q;
  assign bus.busy_o      = (state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= S_IDLE;
      last_gnt <= IDX_W'(N_REQ - 1);
      owner    <= '0;
      cnt      <= '0;
      opt_q    <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      rdata_q  <= '0;
      rvld_q   <= '0;
    end else begin
      opt_q  <= IDLE;
      rvld_q <= '0;
      unique case (state)
        S_IDLE: begin
          if (|bus.req_vld_i) begin
            last_gnt <= win_idx;
            owner    <= win_idx;
            addr_q   <= bus.req_addr_i[win_idx];
            data_q   <= bus.req_wdata_i[win_idx];
            // Illegal/IDLE commands are consumed here without touching the bus
            if (cmd_legal(win_cmd)) begin
              opt_q <= win_cmd;
              state <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          if (opt_q == WRITE) begin
            state <= S_IDLE;
          end else if (RD_LAT == 0) begin
            rdata_q <= bus.cmd_rdata_i;
            rvld_q  <= N_REQ'(1) << owner;
            state   <= S_RESP;
          end else begin
            cnt   <= '0;
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == CNT_W'(RD_LAT - 1)) begin
            cnt     <= '0;
            rdata_q <= bus.cmd_rdata_i;
            rvld_q  <= N_REQ'(1) << owner;
            state   <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RESP: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_cmd_arb.sv
// Bench for div_cmd_arb: directed vector table, corner sequences, and random traffic
// checked against a transaction-timing model.
module tb_div_cmd_arb;
  import div_arb_pkg::*;

  localparam int N  = 3;
  localparam int L  = 1;
  localparam int NC = 400;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div_cmd_arb_if #(.N_REQ(N)) b1 ();
  div_cmd_arb_if #(.N_REQ(N)) b0 ();
  div_cmd_arb_if #(.N_REQ(N)) b7 ();

  div_cmd_arb #(.N_REQ(N), .RD_LAT(L)) dut    (.clk_i(clk), .rst_i(rst), .bus(b1));
  div_cmd_arb #(.N_REQ(N), .RD_LAT(0)) dut_l0 (.clk_i(clk), .rst_i(rst), .bus(b0));
  div_cmd_arb #(.N_REQ(N), .RD_LAT(7)) dut_l7 (.clk_i(clk), .rst_i(rst), .bus(b7));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  typedef struct {
    int                k;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wd;
    logic [DATA_W-1:0] rd;
    logic [N-1:0]      e_gnt;
    logic [1:0]        e_opt;
    logic [N-1:0]      e_rvld;
    int                e_busy;
  } vec_t;

  vec_t tv[6];

  // Random-phase model: per-cycle expected outputs derived from the timing rules
  logic [1:0]        m_opt  [NC+16];
  logic [ADDR_W-1:0] m_addr [NC+16];
  logic [DATA_W-1:0] m_data [NC+16];
  logic [N-1:0]      m_rvld [NC+16];
  int                m_src  [NC+16];
  bit                m_busy [NC+16];
  logic [DATA_W-1:0] rd_hist[NC+16];

  function automatic int pick(input logic [N-1:0] hv, input int last);
    int w = -1;
`ifdef DIV_CMD_ARB_FIXPRIO_EN
    for (int i = 0; i < N; i++) if (hv[i] && w < 0) w = i;
`else
    for (int i = 1; i <= N; i++) if (hv[(last + i) % N] && w < 0) w = (last + i) % N;
`endif
    return w;
  endfunction

  initial begin
    logic [N-1:0]      hold;
    logic [1:0]        hcmd [N];
    logic [ADDR_W-1:0] haddr[N];
    logic [DATA_W-1:0] hdata[N];
    logic [N-1:0]      e_gnt;
    logic [N-1:0]      seen_rvld;
    int last, free_at, w, r;

    tv[0] = '{0, WRITE,  8'h04, 16'h000A, 16'h0000, 3'b001, WRITE, 3'b000, 1};
    tv[1] = '{1, READ,   8'h08, 16'h0000, 16'h0055, 3'b010, READ,  3'b010, 3};
    tv[2] = '{2, 2'b11,  8'h10, 16'h1111, 16'h0000, 3'b100, IDLE,  3'b000, 0};
    tv[3] = '{0, IDLE,   8'h12, 16'h2222, 16'h0000, 3'b001, IDLE,  3'b000, 0};
    tv[4] = '{2, READ,   8'h3C, 16'h0000, 16'hBEEF, 3'b100, READ,  3'b100, 3};
    tv[5] = '{1, WRITE,  8'h7F, 16'h1234, 16'h0000, 3'b010, WRITE, 3'b000, 1};

    b1.req_vld_i = '0; b1.req_cmd_i = '0; b1.req_addr_i = '0; b1.req_wdata_i = '0; b1.cmd_rdata_i = '0;
    b0.req_vld_i = '0; b0.req_cmd_i = '0; b0.req_addr_i = '0; b0.req_wdata_i = '0; b0.cmd_rdata_i = '0;
    b7.req_vld_i = '0; b7.req_cmd_i = '0; b7.req_addr_i = '0; b7.req_wdata_i = '0; b7.cmd_rdata_i = '0;
    rst = 1'b1;
    tick(); tick();
    smp();
    chk("rst gnt",   32'(b1.req_gnt_o),   0);
    chk("rst rvld",  32'(b1.req_rvld_o),  0);
    chk("rst rdata", 32'(b1.req_rdata_o), 0);
    chk("rst opt",   32'(b1.cmd_opt_o),   0);
    chk("rst addr",  32'(b1.cmd_addr_o),  0);
    chk("rst data",  32'(b1.cmd_data_o),  0);
    chk("rst busy",  32'(b1.busy_o),      0);
    tick();
    rst = 1'b0;

    // Directed single transactions from idle
    foreach (tv[i]) begin
      b1.req_vld_i = '0;
      b1.req_vld_i[tv[i].k]   = 1'b1;
      b1.req_cmd_i[tv[i].k]   = tv[i].cmd;
      b1.req_addr_i[tv[i].k]  = tv[i].addr;
      b1.req_wdata_i[tv[i].k] = tv[i].wd;
      b1.cmd_rdata_i          = tv[i].rd;
      smp();
      chk("tv gnt",   32'(b1.req_gnt_o), 32'(tv[i].e_gnt));
      chk("tv busy0", 32'(b1.busy_o),    0);
      tick();
      b1.req_vld_i = '0;
      for (int j = 1; j <= 4; j++) begin
        smp();
        if (j == 1) begin
          chk("tv opt", 32'(b1.cmd_opt_o), 32'(tv[i].e_opt));
          if (tv[i].e_opt != IDLE) begin
            chk("tv addr", 32'(b1.cmd_addr_o), 32'(tv[i].addr));
            chk("tv data", 32'(b1.cmd_data_o), 32'(tv[i].wd));
          end
        end else begin
          chk("tv opt idle", 32'(b1.cmd_opt_o), 0);
        end
        chk("tv rvld", 32'(b1.req_rvld_o), (j == 2 + L) ? 32'(tv[i].e_rvld) : 0);
        if (j == 2 + L && tv[i].e_rvld != 0)
          chk("tv rdata", 32'(b1.req_rdata_o), 32'(tv[i].rd));
        chk("tv busy", 32'(b1.busy_o), 32'(j <= tv[i].e_busy));
        tick();
      end
    end

    // Illegal SPI command, then contention: search resumes at requester 0
    b1.req_vld_i = 3'b100; b1.req_cmd_i[2] = 2'b11;
    smp();
    chk("ill gnt",  32'(b1.req_gnt_o), 32'h4);
    tick();
    b1.req_vld_i = 3'b111;
    for (int k = 0; k < N; k++) begin
      b1.req_cmd_i[k]   = WRITE;
      b1.req_addr_i[k]  = ADDR_W'(8'h20 + k);
      b1.req_wdata_i[k] = DATA_W'(16'hA000 + k);
    end
    smp();
    chk("ill busy", 32'(b1.busy_o),    0);
    chk("ill opt",  32'(b1.cmd_opt_o), 0);
    for (int i = 0; i < 6; i++) begin
`ifdef DIV_CMD_ARB_FIXPRIO_EN
      w = 0;
`else
      w = i % N;
`endif
      if (i > 0) smp();
      chk("cont gnt", 32'(b1.req_gnt_o), 32'(1) << w);
      tick();
      smp();
      chk("cont gap", 32'(b1.req_gnt_o),  0);
      chk("cont opt", 32'(b1.cmd_opt_o),  32'(WRITE));
      chk("cont adr", 32'(b1.cmd_addr_o), 32'(8'h20 + w));
      tick();
    end
    b1.req_vld_i = '0;
    tick(); tick();

    // Reset during S_WAIT of a host read
    b1.req_vld_i = 3'b001; b1.req_cmd_i[0] = READ; b1.req_addr_i[0] = 8'h44; b1.cmd_rdata_i = 16'h0099;
    smp();
    chk("rr gnt", 32'(b1.req_gnt_o), 32'h1);
    tick();
    b1.req_vld_i = '0;
    tick();
    rst = 1'b1;
    b1.req_vld_i = 3'b001;
    smp();
    chk("mid rst gnt",   32'(b1.req_gnt_o),   0);
    chk("mid rst opt",   32'(b1.cmd_opt_o),   0);
    chk("mid rst addr",  32'(b1.cmd_addr_o),  0);
    chk("mid rst data",  32'(b1.cmd_data_o),  0);
    chk("mid rst rdata", 32'(b1.req_rdata_o), 0);
    chk("mid rst rvld",  32'(b1.req_rvld_o),  0);
    chk("mid rst busy",  32'(b1.busy_o),      0);
    tick();
    rst = 1'b0;
    b1.req_vld_i = '0;
    seen_rvld = '0;
    for (int j = 0; j < 6; j++) begin
      smp();
      seen_rvld |= b1.req_rvld_o;
      tick();
    end
    chk("no rvld after rst", 32'(seen_rvld), 0);
    b1.req_vld_i = 3'b001; b1.req_addr_i[0] = 8'h48; b1.cmd_rdata_i = 16'h0077;
    smp();
    chk("post rst gnt", 32'(b1.req_gnt_o), 32'h1);
    tick();
    b1.req_vld_i = '0;
    for (int j = 1; j <= 3; j++) begin
      smp();
      chk("post rst rvld", 32'(b1.req_rvld_o), (j == 2 + L) ? 32'h1 : 0);
      if (j == 2 + L) chk("post rst rdata", 32'(b1.req_rdata_o), 32'h77);
      tick();
    end

    // RD_LAT=0 and RD_LAT=7 instances: cmd_rdata_i changes every cycle
    b0.req_vld_i = 3'b001; b0.req_cmd_i[0] = READ; b0.req_addr_i[0] = 8'h11;
    b7.req_vld_i = 3'b001; b7.req_cmd_i[0] = READ; b7.req_addr_i[0] = 8'h11;
    for (int j = 0; j <= 12; j++) begin
      b0.cmd_rdata_i = DATA_W'(16'h0100 + j);
      b7.cmd_rdata_i = DATA_W'(16'h0100 + j);
      smp();
      if (j == 0) begin
        chk("l0 gnt", 32'(b0.req_gnt_o), 32'h1);
        chk("l7 gnt", 32'(b7.req_gnt_o), 32'h1);
      end
      chk("l0 rvld", 32'(b0.req_rvld_o), (j == 2) ? 32'h1 : 0);
      chk("l7 rvld", 32'(b7.req_rvld_o), (j == 9) ? 32'h1 : 0);
      if (j == 2) chk("l0 rdata", 32'(b0.req_rdata_o), 32'h101);
      if (j == 9) chk("l7 rdata", 32'(b7.req_rdata_o), 32'h108);
      chk("l0 busy", 32'(b0.busy_o), 32'(j >= 1 && j <= 2));
      chk("l7 busy", 32'(b7.busy_o), 32'(j >= 1 && j <= 9));
      tick();
      if (j == 0) begin
        b0.req_vld_i = '0;
        b7.req_vld_i = '0;
      end
    end

    // Random traffic against the timing model
    rst = 1'b1;
    b1.req_vld_i = '0;
    tick();
    rst = 1'b0;
    last = N - 1;
    free_at = 0;
    hold = '0;
    for (int k = 0; k < N; k++) begin
      hcmd[k] = IDLE; haddr[k] = '0; hdata[k] = '0;
    end
    for (int c = 0; c < NC + 16; c++) begin
      m_opt[c] = IDLE; m_addr[c] = '0; m_data[c] = '0;
      m_rvld[c] = '0; m_src[c] = 0; m_busy[c] = 1'b0; rd_hist[c] = '0;
    end
    for (int c = 0; c < NC; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!hold[k]) begin
          if ($urandom_range(2) == 0) begin
            hold[k] = 1'b1;
            r = int'($urandom_range(7));
            hcmd[k]  = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 5) ? READ : WRITE;
            haddr[k] = ADDR_W'($urandom);
            hdata[k] = DATA_W'($urandom);
          end
        end else if ($urandom_range(15) == 0) begin
          hold[k] = 1'b0;
        end
        b1.req_cmd_i[k]   = hcmd[k];
        b1.req_addr_i[k]  = haddr[k];
        b1.req_wdata_i[k] = hdata[k];
      end
      b1.req_vld_i   = hold;
      rd_hist[c]     = DATA_W'($urandom);
      b1.cmd_rdata_i = rd_hist[c];

      e_gnt = '0;
      w = -1;
      if (c >= free_at && hold != 0) begin
        w = pick(hold, last);
        last = w;
        e_gnt[w] = 1'b1;
        if (hcmd[w] == WRITE) begin
          m_opt[c+1] = WRITE; m_addr[c+1] = haddr[w]; m_data[c+1] = hdata[w];
          m_busy[c+1] = 1'b1;
          free_at = c + 2;
        end else if (hcmd[w] == READ) begin
          m_opt[c+1] = READ; m_addr[c+1] = haddr[w]; m_data[c+1] = hdata[w];
          for (int j = c + 1; j <= c + 2 + L; j++) m_busy[j] = 1'b1;
          m_rvld[c+2+L] = e_gnt;
          m_src[c+2+L]  = c + 1 + L;
          free_at = c + 3 + L;
        end else begin
          free_at = c + 1;
        end
      end

      smp();
      chk("rnd gnt",  32'(b1.req_gnt_o),  32'(e_gnt));
      chk("rnd opt",  32'(b1.cmd_opt_o),  32'(m_opt[c]));
      chk("rnd busy", 32'(b1.busy_o),     32'(m_busy[c]));
      chk("rnd rvld", 32'(b1.req_rvld_o), 32'(m_rvld[c]));
      if (m_rvld[c] != 0) chk("rnd rdata", 32'(b1.req_rdata_o), 32'(rd_hist[m_src[c]]));
      if (m_opt[c] != IDLE) begin
        chk("rnd addr", 32'(b1.cmd_addr_o), 32'(m_addr[c]));
        chk("rnd data", 32'(b1.cmd_data_o), 32'(m_data[c]));
      end
      if (w >= 0) hold[w] = 1'b0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/div_cmd_arb.md
# div_cmd_arb

Command arbiter that shares the divider block's single register command port (cmd_opt/cmd_addr/cmd_data/cmd_rdata) among N_REQ requesters: host register interface, UART command decoder and SPI command decoder. It grants one requester at a time (round-robin), issues a one-cycle command, and returns read data to the requester that issued it. It sits between the front-end decoders and the divider register file inside div_top.

## Interface
Parameters:
- N_REQ, 3, number of requesters; index 0 host, 1 UART, 2 SPI.
- RD_LAT, 1, cycles from command issue to valid cmd_rdata_i; legal range 0..7.

Ports:
- clk_i  in  1  single clock for all logic.
- rst_i  in  1  asynchronous, active-high reset.
- req_vld_i  in  N_REQ  per-requester command valid; held until granted.
- req_cmd_i  in  2*N_REQ  packed commands, [2k+1:2k] for requester k.
- req_addr_i  in  `ADDR_WIDTH*N_REQ  packed addresses.
- req_wdata_i  in  `DATA_WIDTH*N_REQ  packed write data.
- req_gnt_o  out  N_REQ  one-hot accept; a transfer occurs when vld and gnt are high at the same clock edge.
- req_rvld_o  out  N_REQ  one-cycle read-response pulse to the issuing requester.
- req_rdata_o  out  `DATA_WIDTH  read data, valid while any req_rvld_o bit is high.
- cmd_opt_o  out  2  command to the register file.
- cmd_addr_o  out  `ADDR_WIDTH  command address.
- cmd_data_o  out  `DATA_WIDTH  write data.
- cmd_rdata_i  in  `DATA_WIDTH  register file read data.
- busy_o  out  1  high whenever the state is not IDLE.

## Operation
- Command encoding: IDLE 2'b00, READ 2'b01, WRITE 2'b10. 2'b11 is illegal.
- FSM states: S_IDLE, S_ISSUE, S_WAIT, S_RESP.
- S_IDLE:
  - When any req_vld_i bit is set, the picker selects winner w, and req_gnt_o[w] is asserted combinationally in the same cycle.
  - At the clock edge, the arbiter captures cmd/addr/wdata of w into the cmd_*_o registers and stores w in owner.
  - It then sets last_gnt to w.
- Illegal or IDLE command presented with vld:
  - Still granted and discarded; last_gnt is updated.
  - No bus command is issued, and the state stays S_IDLE.
- S_ISSUE: cmd_opt_o holds the command for exactly one cycle.
  - WRITE goes to S_IDLE.
  - READ goes to S_WAIT; if RD_LAT=0 it goes straight to S_RESP and captures cmd_rdata_i this cycle.
- S_WAIT: a 3-bit counter counts to RD_LAT-1, then cmd_rdata_i is captured into the rdata register and the state goes to S_RESP.
- S_RESP: req_rvld_o[owner]=1 and req_rdata_o is valid for one cycle, then S_IDLE.
- Outside S_ISSUE, cmd_opt_o=IDLE. cmd_addr_o and cmd_data_o hold their last values.
- req_gnt_o is all zeros outside S_IDLE, so at most one command is in flight.
- Round-robin: the search starts at last_gnt+1 mod N_REQ and wraps around. last_gnt resets to N_REQ-1, so requester 0 wins the first contention.

## Timing
- Reset values:
  - cmd_opt_o=2'b00, cmd_addr_o=0, cmd_data_o=0.
  - req_gnt_o=0, req_rvld_o=0, req_rdata_o=0, busy_o=0.
  - state=S_IDLE, last_gnt=N_REQ-1, owner=0, counter=0.
- Write: grant at edge E, cmd_opt_o=WRITE during cycle E..E+1, next grant possible at edge E+2. Throughput is one write per 2 cycles.
- Read: cmd_rdata_i is sampled at edge E+1+RD_LAT, and req_rvld_o is high during cycle E+1+RD_LAT..E+2+RD_LAT. Next grant is possible at E+3+RD_LAT.
- A request that arrives while busy waits; its vld must stay high. A requester dropping vld before grant is legal and loses nothing.
- Reset asserted mid-operation: everything returns to reset values immediately. An in-flight read produces no req_rvld_o, and a pending issue is not driven.

## Configuration
- DIV_CMD_ARB_FIXPRIO_EN defined: fixed priority, lowest index wins (host over UART over SPI). last_gnt is unused.
- DIV_CMD_ARB_FIXPRIO_EN undefined (default): round-robin as specified above.
- All other behaviour is identical in both builds.

## Structure
- Package div_arb_pkg:
  - cmd_e typedef (IDLE/READ/WRITE).
  - arb_state_e typedef.
  - localparam CNT_W=3.
  - `ADDR_WIDTH and `DATA_WIDTH come from param_def.v.
- Sub-module div_rr_pick: purely combinational.
  - Inputs: req vector and last_gnt.
  - Output: one-hot grant plus encoded index.
  - Contains the FIXPRIO macro switch.
- div_cmd_arb holds the FSM, latency counter, output registers and response routing.

## Test plan
- Single write: host vld, WRITE, addr 0x04, wdata 0x0A -> gnt[0] the same cycle; cmd_opt_o=2'b10, addr 0x04, data 0x0A for exactly one cycle; busy_o low two cycles after grant.
- Read with RD_LAT=1: UART READ addr 0x08, cmd_rdata_i=0x55 one cycle after issue -> req_rvld_o=3'b010 one cycle, req_rdata_o=0x55, rvld two cycles after issue.
- Contention: all three vld continuously with WRITE -> grants in order 0,1,2,0,1,2, one every 2 cycles; with DIV_CMD_ARB_FIXPRIO_EN, requester 0 is granted every time.
- Illegal command: SPI cmd 2'b11 -> gnt[2] pulses, cmd_opt_o stays IDLE, busy_o stays 0; the next round-robin search starts at requester 0.
- Reset mid-read: assert rst_i during S_WAIT -> all outputs go to reset values within the cycle; no req_rvld_o ever pulses; the next host read completes normally.
- RD_LAT=0 and RD_LAT=7 builds: rdata is sampled in the ISSUE cycle or 7 cycles after it respectively; rvld timing matches the formula in Timing.
